// File: rtl/spi_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_adc_pkg
// Description : Shared constants, state encoding and byte builders for the
//               SPI ADC scanner.
// Revision    : 1.0
// ============================================================================
package spi_adc_pkg;

    localparam logic [31:0] c_reg_data   = 32'h0000_0000;
    localparam logic [31:0] c_reg_status = 32'h0000_0004;
    localparam logic [31:0] c_reg_cs     = 32'h0000_0008;
    localparam logic [31:0] c_reg_div    = 32'h0000_0030;

    localparam logic [7:0] c_adc_start = 8'h01;
    localparam logic [7:0] c_adc_pad   = 8'h00;
    localparam logic [7:0] c_cs_idle   = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CFG       = 4'd1,
        ST_WAIT_TICK = 4'd2,
        ST_CS_LO     = 4'd3,
        ST_XFER      = 4'd4,
        ST_POLL      = 4'd5,
        ST_RD        = 4'd6,
        ST_CS_HI     = 4'd7,
        ST_NEXT      = 4'd8
    } scan_state_t;

    // Single-ended conversion request for the selected channel.
    function automatic logic [7:0] adc_cmd_byte(input logic [2:0] ch);
        return {1'b1, ch, 4'b0000};
    endfunction

    function automatic logic [7:0] cs_active_val(input int unsigned idx);
        logic [7:0] v;
        v = c_cs_idle;
        v[idx[2:0]] = 1'b0;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_adc_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_adc_scanner_if
// Description : Wishbone master bus between the scanner and the SPI peripheral.
// Revision    : 1.0
// ============================================================================
interface spi_adc_scanner_if;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic        m_ack_i;

    modport master (
        output m_adr_o, m_dat_o, m_sel_o, m_cyc_o, m_stb_o, m_we_o,
        input  m_dat_i, m_ack_i
    );

    modport slave (
        input  m_adr_o, m_dat_o, m_sel_o, m_cyc_o, m_stb_o, m_we_o,
        output m_dat_i, m_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/wb_single_access.sv
`default_nettype none
// ============================================================================
// Module      : wb_single_access
// Description : One non-pipelined Wishbone access per request; done strobes
//               with the ack and rdata carries the bus data in that cycle.
// Revision    : 1.0
// ============================================================================
module wb_single_access (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         req,
    input  wire logic         we,
    input  wire logic [31:0]  adr,
    input  wire logic [31:0]  wdata,
    output logic              done,
    output logic [31:0]       rdata,
    spi_adc_scanner_if.master wb
);

    logic        r_cyc;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
        end else if (r_cyc) begin
            if (wb.m_ack_i) begin
                r_cyc <= 1'b0;
            end
        end else if (req) begin
            r_cyc <= 1'b1;
            r_we  <= we;
            r_adr <= adr;
            r_dat <= wdata;
        end
    end

    assign wb.m_cyc_o = r_cyc;
    assign wb.m_stb_o = r_cyc;
    assign wb.m_we_o  = r_we;
    assign wb.m_adr_o = r_adr;
    assign wb.m_dat_o = r_dat;
    assign wb.m_sel_o = 4'hF;

    assign done  = r_cyc & wb.m_ack_i;
    assign rdata = wb.m_dat_i;

endmodule
`default_nettype wire

// File: rtl/spi_adc_scanner.sv
`default_nettype none
// ============================================================================
// Module      : spi_adc_scanner
// Description : Periodically scans an MCP3008-style ADC through the SPI
//               master peripheral and publishes 10-bit samples.
// Revision    : 1.0
// ============================================================================
module spi_adc_scanner
    import spi_adc_pkg::*;
#(
    parameter int          NUM_CH   = 8,
    parameter int          PERIOD   = 50000,
    parameter logic [7:0]  SPI_DIV  = 8'h0F,
    parameter int          CS_INDEX = 0,
    parameter logic [31:0] BASE_ADR = 32'h0000_0000,
    parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         enable,
    spi_adc_scanner_if.master wb,
    output logic [9:0]        sample_data,
    output logic [2:0]        sample_ch,
    output logic              sample_valid,
    output logic              frame_done,
    output logic              overrun,
    output logic              timeout,
    output logic              busy
);

    localparam int c_cnt_w = $clog2(PERIOD);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_tick_pending;
    logic               w_wrap;
    logic               w_take_tick;

    scan_state_t r_state;
    logic        r_req;
    logic        r_pending;
    logic        r_stop;
    logic        r_good;
    logic [1:0]  r_k;
    logic [2:0]  r_ch;
    logic [15:0] r_poll;
    logic [1:0]  r_hi;
    logic [7:0]  r_lo;

    logic        w_done;
    logic [31:0] w_rdata;
    logic        w_is_access;
    logic        w_acc_we;
    logic [31:0] w_acc_adr;
    logic [31:0] w_acc_wdata;
    logic [7:0]  w_xfer_byte;
    logic        w_unused;

    assign w_wrap      = (r_cnt == c_cnt_w'(PERIOD - 1));
    assign w_take_tick = (r_state == ST_WAIT_TICK) && enable && !r_stop && r_tick_pending;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_cnt          <= '0;
            r_tick_pending <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap) begin
                r_tick_pending <= 1'b1;
            end else if (w_take_tick) begin
                r_tick_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (enable && w_wrap && r_tick_pending) begin
            overrun <= 1'b1;
        end
    end

    always_comb begin
        case (r_k)
            2'd0:    w_xfer_byte = c_adc_start;
            2'd1:    w_xfer_byte = adc_cmd_byte(r_ch);
            default: w_xfer_byte = c_adc_pad;
        endcase
    end

    // Access parameters are decoded from registered state so they stay
    // stable from the request until the access is accepted.
    always_comb begin
        w_is_access = 1'b1;
        w_acc_we    = 1'b1;
        w_acc_adr   = BASE_ADR + c_reg_data;
        w_acc_wdata = '0;
        case (r_state)
            ST_CFG: begin
                w_acc_adr   = BASE_ADR + c_reg_div;
                w_acc_wdata = {24'h0, SPI_DIV};
            end
            ST_CS_LO: begin
                w_acc_adr   = BASE_ADR + c_reg_cs;
                w_acc_wdata = {24'h0, cs_active_val(CS_INDEX)};
            end
            ST_XFER: begin
                w_acc_wdata = {24'h0, w_xfer_byte};
            end
            ST_POLL: begin
                w_acc_we  = 1'b0;
                w_acc_adr = BASE_ADR + c_reg_status;
            end
            ST_RD: begin
                w_acc_we = 1'b0;
            end
            ST_CS_HI: begin
                w_acc_adr   = BASE_ADR + c_reg_cs;
                w_acc_wdata = {24'h0, c_cs_idle};
            end
            default: begin
                w_is_access = 1'b0;
            end
        endcase
    end

    wb_single_access u_access (
        .clk   (clk),
        .reset (reset),
        .req   (r_req),
        .we    (w_acc_we),
        .adr   (w_acc_adr),
        .wdata (w_acc_wdata),
        .done  (w_done),
        .rdata (w_rdata),
        .wb    (wb)
    );

    assign w_unused = ^w_rdata[31:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_req        <= 1'b0;
            r_pending    <= 1'b0;
            r_stop       <= 1'b0;
            r_good       <= 1'b0;
            r_k          <= 2'd0;
            r_ch         <= 3'd0;
            r_poll       <= 16'd0;
            r_hi         <= 2'd0;
            r_lo         <= 8'd0;
            sample_data  <= 10'd0;
            sample_ch    <= 3'd0;
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            r_req        <= 1'b0;
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (!enable) begin
                r_stop <= 1'b1;
            end
            if (w_is_access && !r_pending) begin
                r_req     <= 1'b1;
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_stop <= 1'b0;
                    if (enable) begin
                        r_state <= ST_CFG;
                    end
                end
                ST_CFG: begin
                    if (w_done) begin
                        r_pending <= 1'b0;
                        r_state   <= ST_WAIT_TICK;
                    end
                end
                ST_WAIT_TICK: begin
                    if (!enable || r_stop) begin
                        r_state <= ST_IDLE;
                    end else if (r_tick_pending) begin
                        r_ch    <= 3'd0;
                        r_state <= ST_CS_LO;
                    end
                end
                ST_CS_LO: begin
                    if (w_done) begin
                        r_pending <= 1'b0;
                        r_k       <= 2'd0;
                        r_good    <= 1'b1;
                        r_state   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_done) begin
                        r_pending <= 1'b0;
                        r_poll    <= 16'd0;
                        r_state   <= ST_POLL;
                    end
                end
                ST_POLL: begin
                    if (w_done) begin
                        r_pending <= 1'b0;
                        if (!w_rdata[0]) begin
                            r_state <= ST_RD;
                        end else if (r_poll == POLL_MAX - 16'd1) begin
                            timeout <= 1'b1;
                            r_good  <= 1'b0;
                            r_state <= ST_CS_HI;
                        end else begin
                            r_poll <= r_poll + 16'd1;
                        end
                    end
                end
                ST_RD: begin
                    if (w_done) begin
                        r_pending <= 1'b0;
                        if (r_k == 2'd1) begin
                            r_hi <= w_rdata[1:0];
                        end
                        if (r_k == 2'd2) begin
                            r_lo    <= w_rdata[7:0];
                            r_state <= ST_CS_HI;
                        end else begin
                            r_k     <= r_k + 2'd1;
                            r_state <= ST_XFER;
                        end
                    end
                end
                ST_CS_HI: begin
                    if (w_done) begin
                        r_pending <= 1'b0;
                        if (r_good) begin
                            sample_data  <= {r_hi, r_lo};
                            sample_ch    <= r_ch;
                            sample_valid <= 1'b1;
                        end
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (r_ch == 3'(NUM_CH - 1)) begin
                        frame_done <= 1'b1;
                        r_state    <= (r_stop || !enable) ? ST_IDLE : ST_WAIT_TICK;
                    end else if (r_stop || !enable) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ch    <= r_ch + 3'd1;
                        r_state <= ST_CS_LO;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE) && (r_state != ST_WAIT_TICK);

endmodule
`default_nettype wire

// File: tb/tb_spi_adc_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_adc_scanner
// Description : Directed bench for spi_adc_scanner with a small SPI/ADC model.
// Revision    : 1.0
// ============================================================================
module tb_spi_adc_scanner;

    logic clk = 1'b0;
    logic reset;
    logic enable_a;
    logic enable_b;

    always #5 clk = ~clk;

    spi_adc_scanner_if bus_a ();
    spi_adc_scanner_if bus_b ();

    logic [9:0] sd_a, sd_b;
    logic [2:0] sc_a, sc_b;
    logic       sv_a, fd_a, ov_a, to_a, bz_a;
    logic       sv_b, fd_b, ov_b, to_b, bz_b;

    spi_adc_scanner #(
        .NUM_CH(8), .PERIOD(1000), .SPI_DIV(8'h0F), .CS_INDEX(0),
        .BASE_ADR(32'h0000_0000), .POLL_MAX(16'd4)
    ) dut_a (
        .clk(clk), .reset(reset), .enable(enable_a), .wb(bus_a),
        .sample_data(sd_a), .sample_ch(sc_a), .sample_valid(sv_a),
        .frame_done(fd_a), .overrun(ov_a), .timeout(to_a), .busy(bz_a)
    );

    spi_adc_scanner #(
        .NUM_CH(8), .PERIOD(2), .SPI_DIV(8'h0F), .CS_INDEX(0),
        .BASE_ADR(32'h0000_0000), .POLL_MAX(16'hFFFF)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .wb(bus_b),
        .sample_data(sd_b), .sample_ch(sc_b), .sample_valid(sv_b),
        .frame_done(fd_b), .overrun(ov_b), .timeout(to_b), .busy(bz_b)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [31:0] cyc;
    } acc_t;

    typedef struct packed {
        logic [2:0] ch;
        logic [9:0] data;
    } smp_t;

    acc_t alog[$];
    acc_t wlog[$];
    smp_t sq[$];

    logic [9:0]  adc_val [8] = '{10'h001, 10'h3FF, 10'h155, 10'h2A5,
                                 10'h0F0, 10'h30C, 10'h1AB, 10'h246};
    logic [31:0] cycle_no   = 32'd0;
    logic [7:0]  rsp        = 8'h00;
    logic [1:0]  bidx       = 2'd0;
    logic [2:0]  cur_ch     = 3'd0;
    int          busy_polls = 0;
    logic        stuck_en   = 1'b0;
    logic        stuck_act  = 1'b0;
    logic [2:0]  stuck_ch   = 3'd5;
    int          fd_cnt_a   = 0;
    int          fd_cnt_b   = 0;
    int          n_checks   = 0;
    int          n_fail     = 0;

    // SPI peripheral model: run stays high for two status polls after each
    // byte, or indefinitely once the stuck channel has been commanded.
    always @(posedge clk) begin
        cycle_no <= cycle_no + 32'd1;
        if (reset) begin
            bus_a.m_ack_i <= 1'b0;
            bus_a.m_dat_i <= 32'h0;
            bidx          <= 2'd0;
            stuck_act     <= 1'b0;
            busy_polls    <= 0;
        end else begin
            bus_a.m_ack_i <= 1'b0;
            if (bus_a.m_cyc_o && bus_a.m_stb_o && !bus_a.m_ack_i) begin
                bus_a.m_ack_i <= 1'b1;
                alog.push_back({bus_a.m_adr_o, bus_a.m_dat_o, bus_a.m_we_o, cycle_no});
                if (bus_a.m_we_o) begin
                    wlog.push_back({bus_a.m_adr_o, bus_a.m_dat_o, 1'b1, cycle_no});
                    if (bus_a.m_adr_o == 32'h08) begin
                        bidx      <= 2'd0;
                        stuck_act <= 1'b0;
                    end else if (bus_a.m_adr_o == 32'h00) begin
                        busy_polls <= 2;
                        bidx       <= bidx + 2'd1;
                        case (bidx)
                            2'd0: rsp <= 8'h5A;
                            2'd1: begin
                                cur_ch <= bus_a.m_dat_o[6:4];
                                rsp    <= {6'b101101, adc_val[bus_a.m_dat_o[6:4]][9:8]};
                                if (stuck_en && bus_a.m_dat_o[6:4] == stuck_ch)
                                    stuck_act <= 1'b1;
                            end
                            default: rsp <= adc_val[cur_ch][7:0];
                        endcase
                    end
                end else if (bus_a.m_adr_o == 32'h04) begin
                    bus_a.m_dat_i <= {31'h0, (stuck_act || busy_polls != 0)};
                    if (busy_polls > 0) busy_polls <= busy_polls - 1;
                end else begin
                    bus_a.m_dat_i <= {24'h0, rsp};
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset) bus_b.m_ack_i <= 1'b0;
        else       bus_b.m_ack_i <= bus_b.m_cyc_o && bus_b.m_stb_o && !bus_b.m_ack_i;
    end
    assign bus_b.m_dat_i = 32'h0;

    always @(negedge clk) begin
        if (sv_a) sq.push_back({sc_a, sd_a});
        if (fd_a) fd_cnt_a <= fd_cnt_a + 1;
        if (fd_b) fd_cnt_b <= fd_cnt_b + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic acc_t wget(input int idx);
        acc_t e;
        e = '0;
        if (idx < wlog.size()) e = wlog[idx];
        return e;
    endfunction

    function automatic smp_t sget(input int idx);
        smp_t s;
        s = '1;
        if (idx < sq.size()) s = sq[idx];
        return s;
    endfunction

    task automatic check_write(input string tag, input int idx, input logic [31:0] adr,
                               input logic [7:0] dat);
        acc_t e;
        e = wget(idx);
        check_val({tag, "_adr"}, e.adr, adr);
        check_val({tag, "_dat"}, e.dat, {24'h0, dat});
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while (fd_cnt_a < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check_val(tag, 32'(fd_cnt_a >= n), 32'd1);
    endtask

    initial begin
        int   i;
        int   polls;
        acc_t a0;
        acc_t a1;
        smp_t s;
        logic [2:0] f2_ch [7];

        f2_ch = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        reset    = 1'b1;
        enable_a = 1'b0;
        enable_b = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check_val("rst_cyc", 32'(bus_a.m_cyc_o), 32'd0);
        check_val("rst_stb", 32'(bus_a.m_stb_o), 32'd0);
        check_val("rst_flags", 32'({sv_a, fd_a, ov_a, to_a, bz_a}), 32'd0);
        check_val("rst_sample", 32'({sc_a, sd_a}), 32'd0);

        enable_a = 1'b1;
        enable_b = 1'b1;
        repeat (50) @(negedge clk);
        check_val("cfg_count", 32'(wlog.size()), 32'd1);
        check_write("cfg", 0, 32'h30, 8'h0F);
        check_val("wait_busy", 32'(bz_a), 32'd0);
        check_val("pre_tick_samples", 32'(sq.size()), 32'd0);

        wait_frames(1, 2000, "frame1_done");
        check_val("frame1_samples", 32'(sq.size()), 32'd8);
        for (int c = 0; c < 8; c++) begin
            s = sget(c);
            check_val($sformatf("f1_ch%0d", c), 32'(s.ch), 32'(c));
            check_val($sformatf("f1_data%0d", c), 32'(s.data), 32'(adc_val[c]));
        end
        check_val("frame1_done_once", 32'(fd_cnt_a), 32'd1);
        check_write("ch3_cslo", 16, 32'h08, 8'hFE);
        check_write("ch3_b0", 17, 32'h00, 8'h01);
        check_write("ch3_b1", 18, 32'h00, 8'hB0);
        check_write("ch3_b2", 19, 32'h00, 8'h00);
        check_write("ch3_cshi", 20, 32'h08, 8'hFF);
        check_write("ch4_cslo", 21, 32'h08, 8'hFE);
        check_val("b_overrun", 32'(ov_b), 32'd1);
        check_val("b_frames", 32'(fd_cnt_b >= 2), 32'd1);
        check_val("a_no_overrun", 32'(ov_a), 32'd0);
        check_val("a_no_timeout", 32'(to_a), 32'd0);

        stuck_en = 1'b1;
        wait_frames(2, 2000, "frame2_done");
        a0 = wget(1);
        a1 = wget(41);
        check_val("frame_spacing", a1.cyc - a0.cyc, 32'd1000);
        check_val("timeout_set", 32'(to_a), 32'd1);
        check_val("frame2_samples", 32'(sq.size()), 32'd15);
        for (int c = 0; c < 7; c++) begin
            s = sget(8 + c);
            check_val($sformatf("f2_ch%0d", c), 32'(s.ch), 32'(f2_ch[c]));
        end
        check_write("ch5_cmd", 68, 32'h00, 8'hD0);
        check_write("ch5_cshi", 69, 32'h08, 8'hFF);
        a0 = wget(68);
        a1 = wget(69);
        polls = 0;
        foreach (alog[j]) begin
            if (!alog[j].we && alog[j].adr == 32'h04 && alog[j].cyc > a0.cyc && alog[j].cyc < a1.cyc)
                polls++;
        end
        check_val("ch5_polls", 32'(polls), 32'd4);
        check_val("b_overrun_sticky", 32'(ov_b), 32'd1);

        stuck_en = 1'b0;
        i = 0;
        while (wlog.size() < 93 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check_val("ch2_xfer_seen", 32'(wlog.size() >= 93), 32'd1);
        enable_a = 1'b0;
        i = 0;
        while (bz_a && i < 400) begin
            @(negedge clk);
            i++;
        end
        check_val("drop_idle", 32'(bz_a), 32'd0);
        repeat (1500) @(negedge clk);
        check_val("drop_writes", 32'(wlog.size()), 32'd95);
        check_write("drop_cmd", 92, 32'h00, 8'hA0);
        check_write("drop_cshi", 94, 32'h08, 8'hFF);
        check_val("drop_samples", 32'(sq.size()), 32'd18);
        s = sget(17);
        check_val("drop_last_ch", 32'(s.ch), 32'd2);
        check_val("drop_last_data", 32'(s.data), 32'(adc_val[2]));
        check_val("drop_frames", 32'(fd_cnt_a), 32'd2);
        check_val("timeout_sticky", 32'(to_a), 32'd1);

        enable_a = 1'b1;
        i = 0;
        while (!bus_a.m_stb_o && i < 20) begin
            @(negedge clk);
            i++;
        end
        check_val("stb_seen", 32'(bus_a.m_stb_o), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_mid_cyc", 32'(bus_a.m_cyc_o), 32'd0);
        check_val("rst_mid_stb", 32'(bus_a.m_stb_o), 32'd0);
        check_val("rst_mid_flags", 32'({sv_a, fd_a, ov_a, to_a, bz_a}), 32'd0);
        check_val("rst_mid_sample", 32'({sc_a, sd_a}), 32'd0);
        check_val("rst_mid_b", 32'({bus_b.m_cyc_o, ov_b, bz_b}), 32'd0);
        reset    = 1'b0;
        enable_a = 1'b0;
        enable_b = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
